// File: rtl/br_out_arbiter_pkg.sv
// Shared BrLite output types, arbiter FSM state encoding and requester indices.
package DMNIPkg;

    typedef struct packed {
        logic [3:0]  service;
        logic [7:0]  src;
        logic [7:0]  tgt;
        logic [11:0] payload;
    } brlite_out_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } br_arb_state_t;

    localparam int BR_ARB_SW  = 0;
    localparam int BR_ARB_QOS = 1;
    localparam int BR_ARB_PWR = 2;

endpackage

// File: rtl/br_out_arbiter_rr_priority.sv
// Round-robin pick: first requester above last_grant_i, wrapping, requester
// immediately after the last grant having highest priority.
module rr_priority #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    int cand;

    // Walk from farthest to nearest so the nearest requesting index wins last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = (int'(last_grant_i) + i) % N_REQ;
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/br_out_arbiter.sv
// Arbitrates several BrLite send requesters onto the single router local port,
// with a per-grant acceptance timeout and a sticky timeout flag.
//
// state | meaning
// IDLE  | waiting for a request while the local port is free
// ISSUE | br_req_o held to the router, counting cycles toward timeout
// DONE  | one-cycle ack_o pulse to the retired requester
module br_out_arbiter
    import DMNIPkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 1024,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_REQ-1:0]              req_i,
    input  brlite_out_t [N_REQ-1:0]       data_i,
    output logic [N_REQ-1:0]              ack_o,
    input  logic                          br_local_busy_i,
    output logic                          br_req_o,
    input  logic                          br_ack_i,
    output brlite_out_t                   br_data_o,
    output logic                          timeout_o,
    output logic [IDX_W-1:0]              timeout_id_o,
    input  logic                          timeout_clr_i
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    br_arb_state_t     state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic              br_req_q, br_req_d;
    brlite_out_t       data_q, data_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  timeout_id_q, timeout_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rr_valid;
    logic [IDX_W-1:0]  rr_idx;

    // grant_q doubles as last_grant: it only changes when a new grant is made.
    rr_priority #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i        (req_i),
        .last_grant_i (grant_q),
        .valid_o      (rr_valid),
        .idx_o        (rr_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        br_req_d     = br_req_q;
        data_d       = data_q;
        ack_d        = '0;
        timeout_d    = timeout_q;
        timeout_id_d = timeout_id_q;
        cnt_d        = cnt_q;

        if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!br_local_busy_i && rr_valid) begin
                    grant_d  = rr_idx;
                    data_d   = data_i[rr_idx];
                    br_req_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (br_ack_i) begin
                    br_req_d       = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = DONE;
                end else if (TIMEOUT_CYC > 0 && cnt_q == CNT_TERM) begin
                    // Setting here overrides a same-cycle timeout_clr_i.
                    br_req_d       = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    timeout_d      = 1'b1;
                    timeout_id_d   = grant_q;
                    state_d        = DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= IDX_W'(N_REQ - 1);
            br_req_q     <= 1'b0;
            data_q       <= '0;
            ack_q        <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            br_req_q     <= br_req_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ack_o        = ack_q;
    assign br_req_o     = br_req_q;
    assign br_data_o    = data_q;
    assign timeout_o    = timeout_q;
    assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_br_out_arbiter.sv
// Self-checking bench for br_out_arbiter: vector table of grant transactions
// with a retire scoreboard, plus hand sequences for timeout clear and reset.
module tb_br_out_arbiter;
    import DMNIPkg::*;

    logic              clk;
    logic              rst_i;
    logic [2:0]        req_i;
    brlite_out_t [2:0] data_i;
    logic [2:0]        ack_o;
    logic              br_local_busy_i;
    logic              br_req_o;
    logic              br_ack_i;
    brlite_out_t       br_data_o;
    logic              timeout_o;
    logic [1:0]        timeout_id_o;
    logic              timeout_clr_i;

    br_out_arbiter #(
        .N_REQ       (3),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .data_i          (data_i),
        .ack_o           (ack_o),
        .br_local_busy_i (br_local_busy_i),
        .br_req_o        (br_req_o),
        .br_ack_i        (br_ack_i),
        .br_data_o       (br_data_o),
        .timeout_o       (timeout_o),
        .timeout_id_o    (timeout_id_o),
        .timeout_clr_i   (timeout_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        int         busy_cyc;
        int         ack_at;     // ISSUE cycle (1-based) carrying br_ack_i, 0 = never
        int         exp_idx;
        int         exp_issue;  // ISSUE cycles before br_req_o drops
        logic       exp_to;
    } vec_t;

    typedef struct {
        logic [2:0]  ack;
        brlite_out_t data;
        logic        to;
        logic [1:0]  id;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t e_m;
    vec_t vecs[9];
    vec_t none;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < 3; i++) data_i[i] = brlite_out_t'($urandom);
    endtask

    // Retire monitor: every ack_o pulse must match the oldest granted transaction.
    always @(negedge clk) begin
        if (ack_o !== 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {61'd0, ack_o}, 64'd0);
            end else begin
                e_m = exp_q.pop_front();
                chk("ack_vector", {61'd0, ack_o}, {61'd0, e_m.ack});
                chk("ack_data", {32'd0, br_data_o}, {32'd0, e_m.data});
                chk("ack_timeout_flag", {63'd0, timeout_o}, {63'd0, e_m.to});
                if (e_m.to) chk("ack_timeout_id", {62'd0, timeout_id_o}, {62'd0, e_m.id});
            end
        end
    end

    task automatic run_vec(input vec_t v, input vec_t nxt);
        exp_t e;
        int   cyc;
        req_i           = v.req;
        br_local_busy_i = (v.busy_cyc > 0);
        for (int k = 0; k < v.busy_cyc; k++) begin
            @(negedge clk);
            chk("busy_blocks_grant", {63'd0, br_req_o}, 64'd0);
        end
        br_local_busy_i = 1'b0;
        @(negedge clk);
        chk("grant_latency", {63'd0, br_req_o}, 64'd1);
        chk("grant_data", {32'd0, br_data_o}, {32'd0, data_i[v.exp_idx]});
        e.ack  = 3'b001 << v.exp_idx;
        e.data = data_i[v.exp_idx];
        e.to   = v.exp_to;
        e.id   = 2'(v.exp_idx);
        exp_q.push_back(e);
        scramble();
        cyc = 1;
        while (br_req_o === 1'b1 && cyc <= 40) begin
            br_ack_i = (cyc == v.ack_at);
            @(negedge clk);
            br_ack_i = 1'b0;
            if (br_req_o === 1'b1) cyc++;
        end
        chk("issue_cycles", 64'(cyc), 64'(v.exp_issue));
        req_i           = nxt.req;
        br_local_busy_i = (nxt.busy_cyc > 0);
        @(negedge clk);
        chk("done_one_cycle", {61'd0, ack_o}, 64'd0);
        chk("idle_req_low", {63'd0, br_req_o}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        //           req     busy ack idx issue to
        vecs[0] = '{3'b111,  0,   1,  0,  1,    1'b0};
        vecs[1] = '{3'b111,  0,   1,  1,  1,    1'b0};
        vecs[2] = '{3'b111,  0,   2,  2,  2,    1'b0};
        vecs[3] = '{3'b111,  0,   1,  0,  1,    1'b0};
        vecs[4] = '{3'b001,  0,   3,  0,  3,    1'b0};
        vecs[5] = '{3'b010,  10,  2,  1,  2,    1'b0};
        vecs[6] = '{3'b101,  0,   8,  2,  8,    1'b0};
        vecs[7] = '{3'b011,  0,   1,  0,  1,    1'b0};
        vecs[8] = '{3'b100,  0,   0,  2,  8,    1'b1};
        none    = '{3'b000,  0,   0,  0,  0,    1'b0};

        rst_i           = 1'b1;
        req_i           = 3'b000;
        br_local_busy_i = 1'b0;
        br_ack_i        = 1'b0;
        timeout_clr_i   = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        chk("rst_br_req", {63'd0, br_req_o}, 64'd0);
        chk("rst_ack", {61'd0, ack_o}, 64'd0);
        chk("rst_data", {32'd0, br_data_o}, 64'd0);
        chk("rst_timeout", {63'd0, timeout_o}, 64'd0);
        chk("rst_timeout_id", {62'd0, timeout_id_o}, 64'd0);
        rst_i = 1'b0;

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], (k < 8) ? vecs[k+1] : none);
        end

        // Sticky flag survives into IDLE, clear drops it, id is kept.
        chk("timeout_sticky", {63'd0, timeout_o}, 64'd1);
        chk("timeout_id_hold", {62'd0, timeout_id_o}, 64'd2);
        timeout_clr_i = 1'b1;
        @(negedge clk);
        timeout_clr_i = 1'b0;
        chk("timeout_cleared", {63'd0, timeout_o}, 64'd0);
        chk("timeout_id_kept", {62'd0, timeout_id_o}, 64'd2);

        // Reset while ISSUE: no ack pulse, then requester 0 wins first.
        req_i = 3'b110;
        @(negedge clk);
        chk("pre_reset_grant", {63'd0, br_req_o}, 64'd1);
        chk("pre_reset_data", {32'd0, br_data_o}, {32'd0, data_i[1]});
        rst_i = 1'b1;
        req_i = 3'b111;
        @(negedge clk);
        chk("reset_drops_req", {63'd0, br_req_o}, 64'd0);
        chk("reset_no_ack", {61'd0, ack_o}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("regrant_latency", {63'd0, br_req_o}, 64'd1);
        chk("regrant_data", {32'd0, br_data_o}, {32'd0, data_i[0]});
        e_m.ack  = 3'b001;
        e_m.data = data_i[0];
        e_m.to   = 1'b0;
        e_m.id   = 2'd0;
        exp_q.push_back(e_m);
        br_ack_i = 1'b1;
        @(negedge clk);
        br_ack_i = 1'b0;
        req_i    = 3'b000;
        @(negedge clk);
        chk("final_ack_low", {61'd0, ack_o}, 64'd0);
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
